serial_sub: RTL and testbench

SERIAL_SUB -- requirements
Module: serial_sub

---
 rtl/serial_sub.sv | 122 ++++++++++++
 tb/tb_serial_sub.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a - b - c one bit per cycle, LSB first,
// and publishes diff/borrow/ovf together when the last bit is processed.
module serial_sub #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             br_q, br_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic ai, bi, d_bit, br_bit, last_bit;

  // Full-subtractor cell fed by the low bits of the shifting operands.
  assign ai       = a_q[0];
  assign bi       = b_q[0];
  assign d_bit    = ai ^ bi ^ br_q;
  assign br_bit   = (~ai & bi) | (~ai & br_q) | (bi & br_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    br_d     = br_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = c;
          cnt_d   = '0;
          acc_d   = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          state_d = RUN;
        end
      end
      RUN: begin
        a_d          = a_q >> 1;
        b_d          = b_q >> 1;
        br_d         = br_bit;
        acc_d[cnt_q] = d_bit;
        cnt_d        = cnt_q + CW'(1);
        // Result registers change only on the final bit so partial sums stay hidden.
        if (last_bit) begin
          diff_d   = acc_d;
          borrow_d = br_bit;
          ovf_d    = SIGNED ? ((a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q)) : 1'b0;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      br_q     <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      br_q     <= br_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: three instances (W1, W8 unsigned, W8 signed)
// share one clock and reset; a monitor checks every rising done against a queue.
module tb_serial_sub;

  typedef struct {
    int       id;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
    int         start_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  logic       start_s [3];
  logic [7:0] a_s     [3];
  logic [7:0] b_s     [3];
  logic       c_s     [3];
  logic       busy_s  [3];
  logic       done_s  [3];
  logic [7:0] diff_s  [3];
  logic       borrow_s[3];
  logic       ovf_s   [3];
  logic       done_prev[3];
  int         width_s [3];

  logic       diff_w1;
  logic [7:0] diff_u8, diff_s8;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_sub #(.WIDTH(1), .SIGNED(1'b0)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .a(a_s[0][0]), .b(b_s[0][0]),
    .c(c_s[0]), .busy(busy_s[0]), .done(done_s[0]), .diff(diff_w1),
    .borrow(borrow_s[0]), .ovf(ovf_s[0]));

  serial_sub #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .a(a_s[1]), .b(b_s[1]),
    .c(c_s[1]), .busy(busy_s[1]), .done(done_s[1]), .diff(diff_u8),
    .borrow(borrow_s[1]), .ovf(ovf_s[1]));

  serial_sub #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .a(a_s[2]), .b(b_s[2]),
    .c(c_s[2]), .busy(busy_s[2]), .done(done_s[2]), .diff(diff_s8),
    .borrow(borrow_s[2]), .ovf(ovf_s[2]));

  assign diff_s[0] = {7'b0, diff_w1};
  assign diff_s[1] = diff_u8;
  assign diff_s[2] = diff_s8;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every rising done pops one expectation for that instance.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_s[i] === 1'b1 && done_prev[i] !== 1'b1) begin
        if (sb_q.size() == 0) begin
          check($sformatf("spurious_done_dut%0d", i), 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("dut_id", 64'(i), 64'(e.id));
          check($sformatf("diff_dut%0d", i), 64'(diff_s[i]), 64'(e.diff));
          check($sformatf("borrow_dut%0d", i), 64'(borrow_s[i]), 64'(e.borrow));
          check($sformatf("ovf_dut%0d", i), 64'(ovf_s[i]), 64'(e.ovf));
          check($sformatf("latency_dut%0d", i), 64'(cyc - e.start_cyc - 1), 64'(width_s[i]));
          $display("dut%0d result diff=%0h borrow=%0b ovf=%0b at cycle %0d",
                   i, diff_s[i], borrow_s[i], ovf_s[i], cyc);
        end
      end
      done_prev[i] <= done_s[i];
    end
  end

  task automatic launch(int id, logic [7:0] av, logic [7:0] bv, logic cv);
    @(negedge clk);
    a_s[id] = av;
    b_s[id] = bv;
    c_s[id] = cv;
    start_s[id] = 1'b1;
  endtask

  task automatic wait_done(int id);
    int n;
    n = 0;
    while (done_s[id] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (done_s[id] !== 1'b1) check($sformatf("timeout_dut%0d", id), 64'd0, 64'd1);
  endtask

  task automatic run_op(int id, logic [7:0] av, logic [7:0] bv, logic cv,
                        logic [7:0] ed, logic eb, logic eo);
    exp_t e;
    launch(id, av, bv, cv);
    e.id = id; e.diff = ed; e.borrow = eb; e.ovf = eo; e.start_cyc = cyc;
    sb_q.push_back(e);
    @(negedge clk);
    start_s[id] = 1'b0;
    wait_done(id);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    width_s[0] = 1; width_s[1] = 8; width_s[2] = 8;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0; a_s[i] = '0; b_s[i] = '0; c_s[i] = 1'b0;
      done_prev[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_busy_dut%0d", i), 64'(busy_s[i]), 64'd0);
      check($sformatf("rst_done_dut%0d", i), 64'(done_s[i]), 64'd0);
      check($sformatf("rst_diff_dut%0d", i), 64'(diff_s[i]), 64'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // WIDTH=1 full-subtractor truth table
    run_op(0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    run_op(0, 8'd0, 8'd0, 1'b1, 8'd1, 1'b1, 1'b0);
    run_op(0, 8'd0, 8'd1, 1'b0, 8'd1, 1'b1, 1'b0);
    run_op(0, 8'd0, 8'd1, 1'b1, 8'd0, 1'b1, 1'b0);
    run_op(0, 8'd1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0);
    run_op(0, 8'd1, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0);
    run_op(0, 8'd1, 8'd1, 1'b0, 8'd0, 1'b0, 1'b0);
    run_op(0, 8'd1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b0);

    // WIDTH=8 unsigned
    run_op(1, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run_op(1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op(1, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    run_op(1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0);

    // WIDTH=8 signed overflow cases
    run_op(2, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op(2, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run_op(2, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run_op(2, 8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0);

    // start pulsed mid-run with new operands must be ignored
    begin
      exp_t e;
      launch(1, 8'h30, 8'h11, 1'b0);
      e.id = 1; e.diff = 8'h1F; e.borrow = 1'b0; e.ovf = 1'b0; e.start_cyc = cyc;
      sb_q.push_back(e);
      @(negedge clk);
      start_s[1] = 1'b0;
      check("busy_in_run", 64'(busy_s[1]), 64'd1);
      @(negedge clk);
      @(negedge clk);
      a_s[1] = 8'hFF; b_s[1] = 8'h00; c_s[1] = 1'b1; start_s[1] = 1'b1;
      @(negedge clk);
      start_s[1] = 1'b0;
      wait_done(1);
    end

    // asynchronous reset in the middle of a run
    launch(1, 8'h55, 8'h22, 1'b0);
    @(negedge clk);
    start_s[1] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy_s[1]), 64'd0);
    check("abort_done", 64'(done_s[1]), 64'd0);
    check("abort_diff", 64'(diff_s[1]), 64'd0);
    check("abort_borrow", 64'(borrow_s[1]), 64'd0);
    check("abort_ovf", 64'(ovf_s[1]), 64'd0);
    $display("reset asserted mid-run at cycle %0d", cyc);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1, 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

    repeat (12) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
